bit_serial_adder: RTL and testbench

//  Sequential counterpart to the team's combinational subtractor cell: adds two WIDTH-bit operands
//  one bit per clock, LSB first, with a single full-adder cell and a carry flip-flop.

---
 rtl/bit_serial_adder.sv | 82 ++++++++
 tb/tb_bit_serial_adder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder (one full-adder cell plus a carry FF) behind a start/done handshake.
// Define BIT_SERIAL_ADDER_OVF_EN to add a signed-overflow output captured with sum.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
    logic [CW-1:0] cnt;
    logic c, s, c_next;
    assign s = a_sh[0] ^ b_sh[0] ^ c;
    assign c_next = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    // Written as shifts so WIDTH=1 needs no empty part-select
    assign s_next = (s_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
    // Results are captured on the last RUN edge so they are valid in the same cycle done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            cnt       <= '0;
            c         <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    c     <= carry_in;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= s_next;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        sum       <= s_next;
                        carry_out <= c_next;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                        overflow  <= c ^ c_next;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed and random checks of bit_serial_adder against a countdown/arithmetic model.
// Also exercises a WIDTH=1 instance exhaustively.
module tb_bit_serial_adder;
    localparam int W = 8;
    logic clk = 0, rst = 1, start = 0, cin = 0;
    logic [W-1:0] a = '0, b = '0, sum;
    logic busy, done, cout, ovf;
    logic st1 = 0, a1 = 0, b1 = 0, c1 = 0;
    logic s1, busy1, done1, co1, ovf1;
    int total = 0, bad = 0;
    bit armed = 0;
    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
        .busy(busy), .done(done), .sum(sum), .carry_out(cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        , .overflow(ovf)
`endif
    );
    bit_serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .carry_in(c1),
        .busy(busy1), .done(done1), .sum(s1), .carry_out(co1)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        , .overflow(ovf1)
`endif
    );
`ifndef BIT_SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start fixes the exact result and a busy window of W+1 cycles
    int left = 0;
    logic [W:0] pend = '0, e_res = '0;
    logic pend_ovf = 0, e_ovf = 0, e_busy = 0, e_done = 0;
    always @(posedge clk) begin
        if (rst) begin
            left = 0; e_busy = 0; e_done = 0; e_res = '0; e_ovf = 0;
        end else begin
            e_done = 0;
            if (left > 0) begin
                left--;
                if (left == 1) begin
                    e_done = 1; e_res = pend; e_ovf = pend_ovf;
                end
            end else if (start) begin
                left = W + 1;
                pend = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
                pend_ovf = (a[W-1] == b[W-1]) && (pend[W-1] != a[W-1]);
            end
            e_busy = left > 0;
        end
    end

    always @(negedge clk) if (armed) begin
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("sum", sum, e_res[W-1:0]);
        check("carry_out", cout, e_res[W]);
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check("overflow", ovf, e_ovf);
`endif
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc);
        int lat;
        @(negedge clk);
        a = ta; b = tb2; cin = tc; start = 1;
        lat = 0;
        for (int i = 1; i <= 4 * W + 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, W + 1);
    endtask

    initial begin
        int n, nd;
        logic [2:0] v;
        repeat (2) @(negedge clk);
        armed = 1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 0;
        op(8'h5A, 8'h3C, 0);
        check("t1_sum", sum, 8'h96);
        check("t1_cout", cout, 0);
        op(8'hFF, 8'h01, 0);
        check("t2a_sum", sum, 8'h00);
        check("t2a_cout", cout, 1);
        op(8'hFF, 8'h00, 1);
        check("t2b_sum", sum, 8'h00);
        check("t2b_cout", cout, 1);
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 0; start = 1;
        n = 0; nd = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 9);
            if (start) a = 8'hAA;
            n += int'(busy);
            nd += int'(done);
        end
        check("t3_busy_cycles", n, 9);
        check("t3_done_count", nd, 1);
        check("t3_sum_hold", sum, 8'h30);
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t4_busy", busy, 0);
        check("t4_sum", sum, 0);
        check("t4_cout", cout, 0);
        op(8'h03, 8'h04, 1);
        check("t4_fresh_sum", sum, 8'h08);
`ifdef BIT_SERIAL_ADDER_OVF_EN
        op(8'h7F, 8'h01, 0);
        check("t5a_sum", sum, 8'h80);
        check("t5a_ovf", ovf, 1);
        check("t5a_cout", cout, 0);
        op(8'h80, 8'h80, 0);
        check("t5b_sum", sum, 8'h00);
        check("t5b_ovf", ovf, 1);
        check("t5b_cout", cout, 1);
        op(8'h05, 8'h03, 0);
        check("t5c_ovf", ovf, 0);
`endif
        repeat (2000) op(W'($urandom), W'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            a1 = v[0]; b1 = v[1]; c1 = v[2]; st1 = 1;
            @(negedge clk);
            st1 = 0;
            check("w1_busy", busy1, 1);
            check("w1_early_done", done1, 0);
            @(negedge clk);
            check("w1_done", done1, 1);
            check("w1_result", {co1, s1}, 2'(v[0]) + 2'(v[1]) + 2'(v[2]));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
